// File: rtl/add_sub_accum.sv
// Handshaked accumulator stage: LOAD/ADD/SUB/CLR commands applied to a registered
// accumulator, with NZCV status. Define ADD_SUB_ACCUM_SAT_EN for saturating ADD/SUB.
module add_sub_accum #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_operand,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_n,
   output logic             out_z,
   output logic             out_c,
   output logic             out_v
);

   localparam int MSB = WIDTH - 1;
   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_SUB  = 2'b10;
   localparam logic [1:0] OP_CLR  = 2'b11;

   typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

   state_t           r_state;
   state_t           w_stateNext;
   logic [1:0]       r_op;
   logic [WIDTH-1:0] r_operand;
   logic [WIDTH-1:0] r_acc;
   logic             r_n, r_z, r_c, r_v;

   logic             w_isSub;
   logic [WIDTH-1:0] w_bEff;
   logic [WIDTH-1:0] w_sum;
   logic             w_co;
   logic             w_addOvf;
   logic [WIDTH-1:0] w_result;
   logic             w_c, w_v;

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE:    if (in_valid)  w_stateNext = EXEC;
         EXEC:                   w_stateNext = HOLD;
         HOLD:    if (out_ready) w_stateNext = IDLE;
         default:                w_stateNext = IDLE;
      endcase
   end

   // Subtraction is a + ~b + 1, so co doubles as the no-borrow flag.
   assign w_isSub  = (r_op == OP_SUB);
   assign w_bEff   = w_isSub ? ~r_operand : r_operand;
   assign {w_co, w_sum} = {1'b0, r_acc} + {1'b0, w_bEff} + {{WIDTH{1'b0}}, w_isSub};
   assign w_addOvf = (r_acc[MSB] == w_bEff[MSB]) && (w_sum[MSB] != r_acc[MSB]);

   always_comb begin
      w_result = w_sum;
      w_c      = 1'b0;
      w_v      = 1'b0;
      case (r_op)
         OP_LOAD: w_result = r_operand;
         OP_ADD, OP_SUB: begin
            w_c = w_co;
            w_v = w_addOvf;
`ifdef ADD_SUB_ACCUM_SAT_EN
            if (w_addOvf)
               w_result = r_acc[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
         end
         OP_CLR:  w_result = '0;
         default: w_result = w_sum;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_op      <= OP_LOAD;
         r_operand <= '0;
         r_acc     <= '0;
         r_n       <= 1'b0;
         r_z       <= 1'b0;
         r_c       <= 1'b0;
         r_v       <= 1'b0;
      end else begin
         r_state <= w_stateNext;
         if (r_state == IDLE && in_valid) begin
            r_op      <= in_op;
            r_operand <= in_operand;
         end
         if (r_state == EXEC) begin
            r_acc <= w_result;
            r_n   <= w_result[MSB];
            r_z   <= (w_result == '0);
            r_c   <= w_c;
            r_v   <= w_v;
         end
      end
   end

   assign in_ready   = (r_state == IDLE);
   assign out_valid  = (r_state == HOLD);
   assign out_result = r_acc;
   assign out_n      = r_n;
   assign out_z      = r_z;
   assign out_c      = r_c;
   assign out_v      = r_v;

endmodule

// File: tb/tb_add_sub_accum.sv
// Self-checking bench for add_sub_accum: directed table, backpressure and reset
// sequences, then random commands against an arithmetic reference model.
module tb_add_sub_accum;

   localparam int W    = 8;
   localparam int MOD  = 1 << W;
   localparam int HALF = 1 << (W - 1);

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] operand;
      logic [W-1:0] res;
      logic         n, z, c, v;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [1:0]   in_op = 2'b00;
   logic [W-1:0] in_operand = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_result;
   logic         out_n, out_z, out_c, out_v;

   int checks = 0;
   int passed = 0;
   int modelAcc = 0;

   add_sub_accum #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_operand(in_operand),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_n(out_n), .out_z(out_z), .out_c(out_c), .out_v(out_v)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Reference model in signed/unsigned integer arithmetic.
   function automatic vec_t refModel(input int op, input int b, input int a);
      vec_t r;
      int sa, sb, ssum, res;
      sa = (a >= HALF) ? a - MOD : a;
      sb = (b >= HALF) ? b - MOD : b;
      ssum = 0;
      res  = 0;
      r.op = op[1:0];
      r.operand = b[W-1:0];
      r.c = 1'b0;
      r.v = 1'b0;
      case (op)
         0: res = b;
         1: begin res = (a + b) % MOD; r.c = (a + b) >= MOD; ssum = sa + sb; end
         2: begin res = (a - b + MOD) % MOD; r.c = (a >= b); ssum = sa - sb; end
         default: res = 0;
      endcase
      if (op == 1 || op == 2) begin
         r.v = (ssum > HALF - 1) || (ssum < -HALF);
`ifdef ADD_SUB_ACCUM_SAT_EN
         if (r.v) res = (ssum > 0) ? HALF - 1 : HALF;
`endif
      end
      r.res = res[W-1:0];
      r.n = (res >= HALF);
      r.z = (res == 0);
      return r;
   endfunction

   task automatic checkOutput(input string name, input vec_t e);
      check({name, ".result"}, out_result, e.res);
      check({name, ".n"}, out_n, e.n);
      check({name, ".z"}, out_z, e.z);
      check({name, ".c"}, out_c, e.c);
      check({name, ".v"}, out_v, e.v);
   endtask

   // Full command: handshake in, latency check, result check, optional stall, drain.
   task automatic applyStimulus(input string name, input vec_t e, input int holdCycles);
      int cnt;
      @(negedge clk);
      in_op = e.op;
      in_operand = e.operand;
      in_valid = 1'b1;
      cnt = 0;
      while (!in_ready && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      check({name, ".accept"}, in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_operand = W'($urandom);
      @(negedge clk);
      check({name, ".execValid"}, out_valid, 0);
      check({name, ".execReady"}, in_ready, 0);
      @(negedge clk);
      check({name, ".outValid"}, out_valid, 1);
      checkOutput(name, e);
      for (int i = 0; i < holdCycles; i++) begin
         @(negedge clk);
         check({name, ".holdResult"}, out_result, e.res);
         check({name, ".holdValid"}, out_valid, 1);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check({name, ".drainValid"}, out_valid, 0);
      check({name, ".drainReady"}, in_ready, 1);
   endtask

   vec_t table_q[$];
   vec_t e;

   initial begin
`ifdef ADD_SUB_ACCUM_SAT_EN
      table_q = '{
         '{2'd0, 8'h05, 8'h05, 0, 0, 0, 0}, '{2'd1, 8'h03, 8'h08, 0, 0, 0, 0},
         '{2'd0, 8'h05, 8'h05, 0, 0, 0, 0}, '{2'd2, 8'h05, 8'h00, 0, 1, 1, 0},
         '{2'd0, 8'h00, 8'h00, 0, 1, 0, 0}, '{2'd2, 8'h01, 8'hFF, 1, 0, 0, 0},
         '{2'd0, 8'h7F, 8'h7F, 0, 0, 0, 0}, '{2'd1, 8'h01, 8'h7F, 0, 0, 0, 1},
         '{2'd0, 8'h80, 8'h80, 1, 0, 0, 0}, '{2'd2, 8'h01, 8'h80, 1, 0, 1, 1},
         '{2'd0, 8'h33, 8'h33, 0, 0, 0, 0}, '{2'd3, 8'h5A, 8'h00, 0, 1, 0, 0}};
`else
      table_q = '{
         '{2'd0, 8'h05, 8'h05, 0, 0, 0, 0}, '{2'd1, 8'h03, 8'h08, 0, 0, 0, 0},
         '{2'd0, 8'h05, 8'h05, 0, 0, 0, 0}, '{2'd2, 8'h05, 8'h00, 0, 1, 1, 0},
         '{2'd0, 8'h00, 8'h00, 0, 1, 0, 0}, '{2'd2, 8'h01, 8'hFF, 1, 0, 0, 0},
         '{2'd0, 8'h7F, 8'h7F, 0, 0, 0, 0}, '{2'd1, 8'h01, 8'h80, 1, 0, 0, 1},
         '{2'd0, 8'h80, 8'h80, 1, 0, 0, 0}, '{2'd2, 8'h01, 8'h7F, 0, 0, 1, 1},
         '{2'd0, 8'h33, 8'h33, 0, 0, 0, 0}, '{2'd3, 8'h5A, 8'h00, 0, 1, 0, 0}};
`endif

      repeat (3) @(negedge clk);
      check("reset.inReady", in_ready, 1);
      check("reset.outValid", out_valid, 0);
      check("reset.result", out_result, 0);
      check("reset.flags", {out_n, out_z, out_c, out_v}, 0);
      rst_n = 1'b1;

      foreach (table_q[i]) begin
         applyStimulus($sformatf("vec%0d", i), table_q[i], 0);
         e = refModel(table_q[i].op, table_q[i].operand, modelAcc);
         modelAcc = e.res;
      end

      // Backpressure: result stays put while a new command waits upstream.
      e = refModel(0, 8'h10, modelAcc);
      modelAcc = e.res;
      applyStimulus("bpLoad", e, 0);
      @(negedge clk);
      in_op = 2'd0; in_operand = 8'h10; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      @(negedge clk);
      in_op = 2'd1; in_operand = 8'h01; in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i >= 1) begin
            check("bp.stallReady", in_ready, 0);
            check("bp.stallValid", out_valid, 1);
            check("bp.stallResult", out_result, 8'h10);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      check("bp.readyRise", in_ready, 1);
      check("bp.validFall", out_valid, 0);
      @(posedge clk); #1; in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("bp.addValid", out_valid, 1);
      check("bp.addResult", out_result, 8'h11);
      out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      repeat (4) @(negedge clk);
      check("bp.onceValid", out_valid, 0);
      check("bp.onceResult", out_result, 8'h11);
      modelAcc = 8'h11;

      // Reset in EXEC aborts the load.
      @(negedge clk);
      in_op = 2'd0; in_operand = 8'hAA; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      #1; rst_n = 1'b0;
      #1;
      check("rst.outValid", out_valid, 0);
      check("rst.result", out_result, 0);
      check("rst.flags", {out_n, out_z, out_c, out_v}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      check("rst.inReady", in_ready, 1);
      modelAcc = 0;
      e = refModel(1, 1, modelAcc);
      check("rst.modelAdd", e.res, 1);
      modelAcc = e.res;
      applyStimulus("rstAdd", e, 0);

      for (int i = 0; i < 60; i++) begin
         e = refModel($urandom_range(0, 3), $urandom_range(0, MOD - 1), modelAcc);
         modelAcc = e.res;
         applyStimulus($sformatf("rnd%0d", i), e, $urandom_range(0, 2));
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/add_sub_accum.md
# add_sub_accum

Sequential accumulator stage built around the combinational N-bit adder/subtractor (`ci`=1 selects subtract, `co` is carry/no-borrow). It accepts one operand command per valid/ready handshake, applies it to a registered accumulator, and presents the result plus NZCV status flags on a valid/ready output port. It is the control and storage stage that feeds operands to the adder datapath and consumes its sum and carry.

## Interface
- `WIDTH`, default 8: accumulator, operand and result width in bits (≥2).
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `in_valid` input 1: command present.
- `in_ready` output 1: block can accept a command.
- `in_op` input 2: command; 00 LOAD, 01 ADD, 10 SUB, 11 CLR.
- `in_operand` input WIDTH: operand B; ignored for CLR.
- `out_valid` output 1: result and flags valid.
- `out_ready` input 1: downstream accepts result.
- `out_result` output WIDTH: accumulator value after the command.
- `out_n` / `out_z` / `out_c` / `out_v` output 1 each: negative, zero, carry (no-borrow on SUB), signed overflow.

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low.
- FSM states: IDLE, EXEC, HOLD. Reset state is IDLE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`, register `in_op` and `in_operand`, then go to EXEC.
- EXEC: `in_ready`=0. Drive the adder with a=acc, b=operand, ci=(op==SUB). On the next edge, update acc and flags, set `out_valid`, and go to HOLD.
- HOLD: `out_valid`=1 and `in_ready`=0. Result and flags stay stable. On `out_ready`, clear `out_valid` and go to IDLE.
- LOAD: acc=operand; C=0, V=0.
- ADD: acc=acc+operand mod 2^WIDTH; C=co; V=(a[msb]==b[msb]) && (sum[msb]!=a[msb]).
- SUB: acc=acc−operand mod 2^WIDTH; C=co (1 = no borrow); V=(a[msb]!=b[msb]) && (sum[msb]!=a[msb]).
- CLR: acc=0; C=0, V=0.
- N=result[msb] and Z=(result==0) for every op.
- `out_result` always equals the current acc register.
- Reset values: acc=0; `out_result`=0; `out_n`/`out_z`/`out_c`/`out_v`=0; `out_valid`=0; `in_ready`=1 after reset (IDLE).
- Reset asserted in any state aborts the command immediately. No partial update survives.
- `in_valid` in EXEC or HOLD is not accepted. The upstream must hold the command until it sees `in_ready`.
- A captured command is never dropped or re-executed.

## Timing
- Command accepted at edge k: `out_valid` rises after edge k+1. Minimum 3-cycle command period with `out_ready` tied high.
- HOLD→IDLE on the edge where `out_ready`=1. `in_ready` rises in the same cycle `out_valid` falls.
- All outputs are registered or decoded from state. There is no combinational path from `in_*` to `out_*` or from `out_ready` to `in_ready`.
- The adder path sits between acc/operand registers and acc/flag registers, so it is one full cycle.

## Configuration
- `ADD_SUB_ACCUM_SAT_EN` defined: on ADD/SUB with V=1, acc saturates.
  - To 2^(WIDTH−1)−1 when a[msb]==0.
  - To −2^(WIDTH−1) when a[msb]==1.
  - V is still reported as 1. C is the raw adder carry. N and Z are computed from the saturated result.
- `ADD_SUB_ACCUM_SAT_EN` undefined: results wrap modulo 2^WIDTH and there is no saturation logic.

## Test plan
- WIDTH=8: LOAD 0x05, then ADD 0x03 → result 0x08, N=0, Z=0, C=0, V=0, `out_valid` two cycles after acceptance.
- LOAD 0x05, SUB 0x05 → 0x00, Z=1, C=1, V=0. Then LOAD 0x00, SUB 0x01 → 0xFF, N=1, C=0, V=0.
- LOAD 0x7F, ADD 0x01 → wrap build: 0x80, N=1, V=1; SAT build: 0x7F, N=0, V=1. LOAD 0x80, SUB 0x01 → wrap 0x7F, V=1; SAT 0x80, V=1.
- Backpressure: hold `out_ready`=0 for 5 cycles with `in_valid`=1 pending.
  - Result and flags stay stable and `in_ready`=0.
  - The pending command is accepted only after the `out_ready` handshake and executes exactly once.
- Assert `rst_n` low during EXEC after LOAD 0xAA.
  - Immediately: `out_valid`=0, `out_result`=0, flags 0.
  - After release: `in_ready`=1, and ADD 0x01 yields 0x01.
- CLR after LOAD 0x33 → 0x00, Z=1, C=0, V=0, N=0.
